// File: rtl/storage_ele_pkg.sv
// Shared mode encodings and mode classification for the universal storage bank.
package storage_ele_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // True for every mode that moves bits and therefore advances the shift counter.
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) ||
           (mode == MODE_ROR) || (mode == MODE_ROL);
  endfunction

endpackage

// File: rtl/sat_shift_counter.sv
// Saturating event counter with a registered one-cycle pulse on reaching CNT_MAX.
module sat_shift_counter #(
  parameter int CNT_MAX = 8,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc && (r_cnt != MAX_VAL)) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      // Only the step into saturation pulses; further shifts stay quiet.
      r_done <= (r_cnt == LAST_VAL);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/storage_ele_bank.sv
// WIDTH-bit universal register: load/shift/rotate/clear on posedge, shadow copy on negedge.
module storage_ele_bank
  import storage_ele_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_neg,
  output logic             sout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_neg;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sout;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    w_q_next = r_q;
    unique case (mode)
      MODE_LOAD: w_q_next = d;
      MODE_SHR:  w_q_next = {sin, r_q[WIDTH-1:1]};
      MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], sin};
      MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
      MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_CLR:  w_q_next = '0;
      MODE_HOLD, MODE_RSVD: w_q_next = r_q;
      default:   w_q_next = r_q;
    endcase
  end

  // Serial output exposes the bit about to fall off the end being shifted away from.
  always_comb begin
    w_sout = 1'b0;
    case (mode)
      MODE_SHR, MODE_ROR: w_sout = r_q[0];
      MODE_SHL, MODE_ROL: w_sout = r_q[WIDTH-1];
      default:            w_sout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_q_next;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_q_neg <= '0;
    else        r_q_neg <= r_q;
  end

  assign w_cnt_clr = (mode == MODE_LOAD) || (mode == MODE_CLR);
  assign w_cnt_inc = is_shift(mode);

  sat_shift_counter #(
    .CNT_MAX (WIDTH),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .inc   (w_cnt_inc),
    .cnt   (shift_cnt),
    .done  (done)
  );

  assign q     = r_q;
  assign q_neg = r_q_neg;
  assign sout  = w_sout;

endmodule

// File: tb/tb_storage_ele_bank.sv
// Directed bench for storage_ele_bank at WIDTH=8 with hand-computed expectations.
module tb_storage_ele_bank;
  import storage_ele_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic [7:0] q_neg;
  logic       sout;
  logic [3:0] shift_cnt;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  storage_ele_bank #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .d         (d),
    .sin       (sin),
    .q         (q),
    .q_neg     (q_neg),
    .sout      (sout),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-phase, sample sout before the edge, then land 1 time unit past posedge.
  task automatic step(input logic [2:0] m, input logic [7:0] dv, input logic s,
                      output logic so);
    mode = m;
    d    = dv;
    sin  = s;
    #1;
    so = sout;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic       so;
    logic [7:0] pat;
    logic [7:0] exp_q;

    rst_n = 1'b0;
    mode  = MODE_HOLD;
    d     = '0;
    sin   = 1'b0;
    #3;
    check("rst_q", q, 8'h00);
    check("rst_qneg", q_neg, 8'h00);
    check("rst_cnt", shift_cnt, 4'd0);
    check("rst_done", done, 1'b0);
    check("rst_sout", sout, 1'b0);
    #5 rst_n = 1'b1;

    // Reset mid-shift: LOAD FF, 3 x SHR -> 1F, then async reset.
    step(MODE_LOAD, 8'hFF, 1'b0, so);
    step(MODE_SHR, 8'h00, 1'b0, so);
    step(MODE_SHR, 8'h00, 1'b0, so);
    step(MODE_SHR, 8'h00, 1'b0, so);
    check("mid_q", q, 8'h1F);
    check("mid_cnt", shift_cnt, 4'd3);
    check("mid_qneg", q_neg, 8'h3F);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_qneg", q_neg, 8'h00);
    check("arst_cnt", shift_cnt, 4'd0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // LOAD A5 and half-cycle shadow lag.
    step(MODE_LOAD, 8'hA5, 1'b0, so);
    check("load_sout", so, 1'b0);
    check("load_q", q, 8'hA5);
    check("load_cnt", shift_cnt, 4'd0);
    check("load_done", done, 1'b0);
    check("load_qneg_pre", q_neg, 8'h00);
    @(negedge clk);
    #1;
    check("load_qneg", q_neg, 8'hA5);

    // Serialise A5 LSB-first with SHR, sin=0.
    pat   = 8'hA5;
    exp_q = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(MODE_SHR, 8'h00, 1'b0, so);
      exp_q = exp_q >> 1;
      check($sformatf("shr_sout%0d", i), so, pat[i]);
      check($sformatf("shr_q%0d", i), q, exp_q);
      check($sformatf("shr_cnt%0d", i), shift_cnt, i + 1);
      check($sformatf("shr_done%0d", i), done, (i == 7));
    end
    step(MODE_SHR, 8'h00, 1'b0, so);
    check("shr9_q", q, 8'h00);
    check("shr9_cnt", shift_cnt, 4'd8);
    check("shr9_done", done, 1'b0);

    // Rotate round trip.
    step(MODE_LOAD, 8'h81, 1'b0, so);
    check("rot_load_done", done, 1'b0);
    step(MODE_ROL, 8'h00, 1'b0, so);
    check("rol_sout", so, 1'b1);
    check("rol_q", q, 8'h03);
    step(MODE_ROR, 8'h00, 1'b0, so);
    check("ror_sout", so, 1'b1);
    check("ror_q", q, 8'h81);
    check("rot_cnt", shift_cnt, 4'd2);

    // CLR, then SHL with sin=1, then reserved mode holds.
    step(MODE_CLR, 8'h00, 1'b0, so);
    check("clr_q", q, 8'h00);
    check("clr_cnt", shift_cnt, 4'd0);
    step(MODE_SHL, 8'h00, 1'b1, so);
    check("shl1_q", q, 8'h01);
    step(MODE_SHL, 8'h00, 1'b1, so);
    step(MODE_SHL, 8'h00, 1'b1, so);
    step(MODE_SHL, 8'h00, 1'b1, so);
    check("shl4_q", q, 8'h0F);
    check("shl4_cnt", shift_cnt, 4'd4);
    step(MODE_RSVD, 8'hFF, 1'b1, so);
    check("rsvd_sout", so, 1'b0);
    check("rsvd_q", q, 8'h0F);
    check("rsvd_cnt", shift_cnt, 4'd4);
    step(MODE_HOLD, 8'hFF, 1'b1, so);
    check("hold_q", q, 8'h0F);

    // LOAD while cnt = WIDTH-1: counter clears, no pulse.
    step(MODE_LOAD, 8'hFF, 1'b0, so);
    for (int i = 0; i < 7; i++) step(MODE_SHL, 8'h00, 1'b0, so);
    check("pre_cnt7", shift_cnt, 4'd7);
    check("pre_q", q, 8'h80);
    step(MODE_LOAD, 8'hFF, 1'b0, so);
    check("ld7_cnt", shift_cnt, 4'd0);
    check("ld7_done", done, 1'b0);

    // Re-arm: 8 x SHL from FF gives a second done pulse.
    for (int i = 0; i < 8; i++) begin
      step(MODE_SHL, 8'h00, 1'b0, so);
      check($sformatf("rearm_sout%0d", i), so, 1'b1);
      check($sformatf("rearm_done%0d", i), done, (i == 7));
    end
    check("rearm_q", q, 8'h00);
    check("rearm_cnt", shift_cnt, 4'd8);
    step(MODE_HOLD, 8'h00, 1'b0, so);
    check("rearm_done_end", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
